color_bbox: RTL and testbench

COLOR_BBOX -- requirements
Module: color_bbox

---
 rtl/color_bbox_pkg.sv | 35 +++
 rtl/color_bbox_match.sv | 29 ++
 rtl/color_bbox.sv | 229 ++++++++++++++++++++++
 tb/tb_color_bbox.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_bbox_pkg.sv
// Shared OV7670 constants: image geometry, 4:4:4 field positions,
// bounding-box FSM states and midpoint helpers.
package color_bbox_pkg;

    localparam int C_IMG_COLS = 320;
    localparam int C_IMG_ROWS = 240;

    localparam int C_R_HI = 11;
    localparam int C_R_LO = 8;
    localparam int C_G_HI = 7;
    localparam int C_G_LO = 4;
    localparam int C_B_HI = 3;
    localparam int C_B_LO = 0;

    typedef enum logic {
        ST_IDLE,
        ST_ACC
    } state_t;

    // Sum carried one bit wider so the midpoint never wraps.
    function automatic logic [8:0] mid9(input logic [8:0] a,
                                        input logic [8:0] b);
        logic [9:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[9:1];
    endfunction

    function automatic logic [7:0] mid8(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8:1];
    endfunction

endpackage

// File: rtl/color_bbox_match.sv
// Pixel colour classifier: selected channels must reach the
// threshold, unselected channels must stay below it.
module color_match
    import color_bbox_pkg::*;
#(
    parameter int c_nb_buf = 12,
    parameter int c_thr    = 8
) (
    input  logic [c_nb_buf-1:0] pxl_i,
    input  logic [2:0]          sel_i,
    output logic                match_o
);

    localparam logic [4:0] THR = 5'(c_thr);

    logic [3:0] r, g, b;
    logic       r_ok, g_ok, b_ok;

    assign r = pxl_i[C_R_HI:C_R_LO];
    assign g = pxl_i[C_G_HI:C_G_LO];
    assign b = pxl_i[C_B_HI:C_B_LO];

    assign r_ok = sel_i[2] ? ({1'b0, r} >= THR) : ({1'b0, r} < THR);
    assign g_ok = sel_i[1] ? ({1'b0, g} >= THR) : ({1'b0, g} < THR);
    assign b_ok = sel_i[0] ? ({1'b0, b} >= THR) : ({1'b0, b} < THR);

    assign match_o = (sel_i != 3'b000) && r_ok && g_ok && b_ok;

endmodule

// File: rtl/color_bbox.sv
// Snoops the processed-pixel write stream and reports the bounding
// box, centroid and count of colour-matching pixels per frame.
module color_bbox
    import color_bbox_pkg::*;
#(
    parameter int c_img_cols    = C_IMG_COLS,
    parameter int c_img_rows    = C_IMG_ROWS,
    parameter int c_nb_img_pxls = 17,
    parameter int c_nb_buf      = 12,
    parameter int c_thr         = 8,
    parameter int c_min_pxls    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     proc_we,
    input  logic [c_nb_img_pxls-1:0] proc_addr,
    input  logic [c_nb_buf-1:0]      proc_pxl,
    input  logic [2:0]               sel,
    output logic                     valid,
    output logic                     frame_err,
    output logic                     found,
    output logic [8:0]               xmin,
    output logic [8:0]               xmax,
    output logic [7:0]               ymin,
    output logic [7:0]               ymax,
    output logic [8:0]               cx,
    output logic [7:0]               cy,
    output logic [c_nb_img_pxls-1:0] count
);

    localparam int NA = c_nb_img_pxls;
    localparam logic [NA-1:0] LAST = NA'(c_img_cols * c_img_rows - 1);
    localparam logic [NA-1:0] MIN_CNT = NA'(c_min_pxls);
    localparam logic [8:0] COL_END = 9'(c_img_cols - 1);

    state_t state_q, state_d;
    logic [NA-1:0] exp_q, exp_d, cnt_q, cnt_d;
    logic [8:0] col_q, col_d, xmin_q, xmin_d, xmax_q, xmax_d;
    logic [7:0] row_q, row_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [2:0] sel_q, sel_d;

    logic valid_q, valid_d, err_q, err_d, found_q, found_d;
    logic [NA-1:0] rcnt_q, rcnt_d;
    logic [8:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d, rcx_q, rcx_d;
    logic [7:0] rymin_q, rymin_d, rymax_q, rymax_d, rcy_q, rcy_d;

    logic start, hit, bad, match;
    logic [2:0] msel;
    logic [8:0] pcol, bxmin, bxmax, nxmin, nxmax;
    logic [7:0] prow, bymin, bymax, nymin, nymax;
    logic [NA-1:0] bcnt, ncnt;

    assign start = proc_we && (proc_addr == '0);
    assign hit = proc_we && (state_q == ST_ACC) && !start
              && (proc_addr == exp_q);
    assign bad = proc_we && (state_q == ST_ACC) && !start
              && (proc_addr != exp_q);
    assign msel = start ? sel : sel_q;

    color_match #(
        .c_nb_buf(c_nb_buf),
        .c_thr   (c_thr)
    ) u_match (
        .pxl_i  (proc_pxl),
        .sel_i  (msel),
        .match_o(match)
    );

    // A frame start sees empty accumulators, so pixel 0 folds in now.
    always_comb begin
        pcol  = start ? '0 : col_q;
        prow  = start ? '0 : row_q;
        bcnt  = start ? '0 : cnt_q;
        bxmin = start ? '0 : xmin_q;
        bxmax = start ? '0 : xmax_q;
        bymin = start ? '0 : ymin_q;
        bymax = start ? '0 : ymax_q;
        ncnt  = bcnt;
        nxmin = bxmin;
        nxmax = bxmax;
        nymin = bymin;
        nymax = bymax;
        if (match) begin
            ncnt = bcnt + NA'(1);
            if (bcnt == '0) begin
                nxmin = pcol;
                nxmax = pcol;
                nymin = prow;
                nymax = prow;
            end else begin
                if (pcol < bxmin) nxmin = pcol;
                if (pcol > bxmax) nxmax = pcol;
                if (prow < bymin) nymin = prow;
                if (prow > bymax) nymax = prow;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        found_d = found_q;
        rcnt_d  = rcnt_q;
        rxmin_d = rxmin_q;
        rxmax_d = rxmax_q;
        rymin_d = rymin_q;
        rymax_d = rymax_q;
        rcx_d   = rcx_q;
        rcy_d   = rcy_q;
        if (start || hit) begin
            cnt_d  = ncnt;
            xmin_d = nxmin;
            xmax_d = nxmax;
            ymin_d = nymin;
            ymax_d = nymax;
            if (pcol == COL_END) begin
                col_d = '0;
                row_d = prow + 8'd1;
            end else begin
                col_d = pcol + 9'd1;
                row_d = prow;
            end
        end
        unique case (1'b1)
            start: begin
                state_d = ST_ACC;
                err_d   = (state_q == ST_ACC);
                sel_d   = sel;
                exp_d   = NA'(1);
            end
            hit: begin
                exp_d = exp_q + NA'(1);
                if (proc_addr == LAST) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b1;
                    found_d = (ncnt >= MIN_CNT);
                    rcnt_d  = ncnt;
                    rxmin_d = nxmin;
                    rxmax_d = nxmax;
                    rymin_d = nymin;
                    rymax_d = nymax;
                    rcx_d   = mid9(nxmin, nxmax);
                    rcy_d   = mid8(nymin, nymax);
                end
            end
            bad: begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                exp_d   = '0;
                cnt_d   = '0;
                col_d   = '0;
                row_d   = '0;
                xmin_d  = '0;
                xmax_d  = '0;
                ymin_d  = '0;
                ymax_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            found_q <= 1'b0;
            rcnt_q  <= '0;
            rxmin_q <= '0;
            rxmax_q <= '0;
            rymin_q <= '0;
            rymax_q <= '0;
            rcx_q   <= '0;
            rcy_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            found_q <= found_d;
            rcnt_q  <= rcnt_d;
            rxmin_q <= rxmin_d;
            rxmax_q <= rxmax_d;
            rymin_q <= rymin_d;
            rymax_q <= rymax_d;
            rcx_q   <= rcx_d;
            rcy_q   <= rcy_d;
        end
    end

    assign valid     = valid_q;
    assign frame_err = err_q;
    assign found     = found_q;
    assign count     = rcnt_q;
    assign xmin      = rxmin_q;
    assign xmax      = rxmax_q;
    assign ymin      = rymin_q;
    assign ymax      = rymax_q;
    assign cx        = rcx_q;
    assign cy        = rcy_q;

endmodule

// File: tb/tb_color_bbox.sv
// Bench for color_bbox: directed frames on a reduced 40x24 image,
// frame-level reference model checked every cycle plus literal pins.
module tb_color_bbox;

    localparam int COLS = 40;
    localparam int ROWS = 24;
    localparam int NPIX = COLS * ROWS;
    localparam int NA   = 17;
    localparam int MINP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          proc_we = 1'b0;
    logic [NA-1:0] proc_addr = '0;
    logic [11:0]   proc_pxl = '0;
    logic [2:0]    sel = '0;
    logic          valid, frame_err, found;
    logic [8:0]    xmin, xmax, cx;
    logic [7:0]    ymin, ymax, cy;
    logic [NA-1:0] count;

    int  checks = 0;
    int  errors = 0;
    bit  run_cmp = 1'b0;

    logic [11:0] img [NPIX];

    always #10 clk = ~clk;

    color_bbox #(
        .c_img_cols   (COLS),
        .c_img_rows   (ROWS),
        .c_nb_img_pxls(NA),
        .c_nb_buf     (12),
        .c_thr        (8),
        .c_min_pxls   (MINP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .proc_we  (proc_we),
        .proc_addr(proc_addr),
        .proc_pxl (proc_pxl),
        .sel      (sel),
        .valid    (valid),
        .frame_err(frame_err),
        .found    (found),
        .xmin     (xmin),
        .xmax     (xmax),
        .ymin     (ymin),
        .ymax     (ymax),
        .cx       (cx),
        .cy       (cy),
        .count    (count)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit       in_frame = 1'b0;
    int       exp_a = 0;
    logic [2:0] fsel = '0;
    int       qx[$];
    int       qy[$];
    int       m_valid = 0, m_err = 0, m_found = 0, m_count = 0;
    int       m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0;
    int       m_cx = 0, m_cy = 0;

    function automatic bit pix_match(input logic [11:0] p,
                                     input logic [2:0] s);
        int ch [3];
        bit want;
        if (s == 3'b000) return 1'b0;
        ch[0] = int'(p[11:8]);
        ch[1] = int'(p[7:4]);
        ch[2] = int'(p[3:0]);
        for (int i = 0; i < 3; i++) begin
            want = s[2-i];
            if (want != (ch[i] >= 8)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clear();
        in_frame = 1'b0;
        exp_a = 0;
        qx.delete();
        qy.delete();
        m_valid = 0; m_err = 0; m_found = 0; m_count = 0;
        m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
        m_cx = 0; m_cy = 0;
    endtask

    task automatic model_publish();
        m_count = qx.size();
        m_found = (m_count >= MINP) ? 1 : 0;
        m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
        if (m_count > 0) begin
            m_xmin = qx[0]; m_xmax = qx[0];
            m_ymin = qy[0]; m_ymax = qy[0];
            foreach (qx[i]) begin
                if (qx[i] < m_xmin) m_xmin = qx[i];
                if (qx[i] > m_xmax) m_xmax = qx[i];
                if (qy[i] < m_ymin) m_ymin = qy[i];
                if (qy[i] > m_ymax) m_ymax = qy[i];
            end
        end
        m_cx = (m_xmin + m_xmax) / 2;
        m_cy = (m_ymin + m_ymax) / 2;
        m_valid = 1;
    endtask

    task automatic model_write(input int a, input logic [11:0] p,
                               input logic [2:0] s);
        if (a == 0) begin
            if (in_frame) m_err = 1;
            in_frame = 1'b1;
            fsel = s;
            exp_a = 0;
            qx.delete();
            qy.delete();
        end else if (!in_frame) begin
            return;
        end
        if (a != exp_a) begin
            m_err = 1;
            in_frame = 1'b0;
            return;
        end
        if (pix_match(p, fsel)) begin
            qx.push_back(a % COLS);
            qy.push_back(a / COLS);
        end
        exp_a++;
        if (a == NPIX - 1) begin
            model_publish();
            in_frame = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                m_valid = 0;
                m_err = 0;
                if (proc_we) model_write(int'(proc_addr), proc_pxl, sel);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                check("valid", int'(valid), m_valid);
                check("frame_err", int'(frame_err), m_err);
                check("found", int'(found), m_found);
                check("count", int'(count), m_count);
                check("xmin", int'(xmin), m_xmin);
                check("xmax", int'(xmax), m_xmax);
                check("ymin", int'(ymin), m_ymin);
                check("ymax", int'(ymax), m_ymax);
                check("cx", int'(cx), m_cx);
                check("cy", int'(cy), m_cy);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int a, input logic [11:0] p,
                      input logic [2:0] s);
        @(posedge clk);
        #1;
        proc_we = 1'b1;
        proc_addr = NA'(a);
        proc_pxl = p;
        sel = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            proc_we = 1'b0;
            proc_addr = NA'(200);
            proc_pxl = 12'hF00;
            sel = 3'b100;
        end
    endtask

    task automatic frame(input int first, input int last,
                         input logic [2:0] s, input int chg_at,
                         input logic [2:0] s2, input bit gaps);
        for (int a = first; a <= last; a++) begin
            wr(a, img[a], (a >= chg_at) ? s2 : s);
            if (gaps && (a % 7 == 3)) idle(1);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = 12'h000;
    endtask

    task automatic box_img();
        clear_img();
        for (int y = 5; y <= 9; y++)
            for (int x = 10; x <= 19; x++)
                img[y * COLS + x] = 12'hF00;
        img[3] = 12'hFF0;
        img[NPIX - 1] = 12'h707;
    endtask

    task automatic pin_box();
        check("lit_count50", int'(count), 50);
        check("lit_found1", int'(found), 1);
        check("lit_xmin", int'(xmin), 10);
        check("lit_xmax", int'(xmax), 19);
        check("lit_ymin", int'(ymin), 5);
        check("lit_ymax", int'(ymax), 9);
        check("lit_cx", int'(cx), 14);
        check("lit_cy", int'(cy), 7);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        run_cmp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(valid), 0);
        check("rst_count", int'(count), 0);
        #2 rst_n = 1'b1;

        // stray write while idle is ignored
        wr(5, 12'hF00, 3'b100);
        idle(2);

        // all-zero frame
        clear_img();
        frame(0, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b0);
        idle(1);
        @(negedge clk);
        check("lit_valid_pulse", int'(valid), 1);
        check("lit_zero_found", int'(found), 0);
        check("lit_zero_count", int'(count), 0);
        check("lit_zero_xmax", int'(xmax), 0);
        @(negedge clk);
        check("lit_valid_once", int'(valid), 0);
        idle(2);

        // red box, with idle gaps inside the frame
        box_img();
        frame(0, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b1);
        idle(3);
        pin_box();

        // same frame, green select
        frame(0, NPIX - 1, 3'b010, NPIX, 3'b010, 1'b0);
        idle(3);
        check("lit_green_count", int'(count), 0);
        check("lit_green_found", int'(found), 0);

        // select changes mid-frame: latched red must persist
        frame(0, NPIX - 1, 3'b100, 300, 3'b010, 1'b0);
        idle(3);
        pin_box();

        // sel=0 matches nothing
        frame(0, NPIX - 1, 3'b000, NPIX, 3'b000, 1'b0);
        idle(3);
        check("lit_sel0_count", int'(count), 0);

        // address skip aborts the frame
        frame(0, 100, 3'b100, NPIX, 3'b100, 1'b0);
        wr(200, img[200], 3'b100);
        idle(1);
        @(negedge clk);
        check("lit_err_pulse", int'(frame_err), 1);
        check("lit_err_novalid", int'(valid), 0);
        idle(2);
        frame(0, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b0);
        idle(3);
        pin_box();

        // addr 0 inside a frame restarts in the same cycle
        frame(0, 50, 3'b100, NPIX, 3'b100, 1'b0);
        wr(0, img[0], 3'b100);
        idle(1);
        @(negedge clk);
        check("lit_restart_err", int'(frame_err), 1);
        frame(1, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b0);
        idle(3);
        pin_box();

        // three green pixels, including the very last one
        clear_img();
        img[0] = 12'h0F0;
        img[45] = 12'h0F0;
        img[NPIX - 1] = 12'h0F0;
        frame(0, NPIX - 1, 3'b010, NPIX, 3'b010, 1'b0);
        idle(3);
        check("lit_three_count", int'(count), 3);
        check("lit_three_found", int'(found), 0);
        check("lit_three_xmax", int'(xmax), 39);
        check("lit_three_ymax", int'(ymax), 23);
        check("lit_three_cx", int'(cx), 19);
        check("lit_three_cy", int'(cy), 11);

        // reset mid-frame, tail of that frame ignored
        box_img();
        frame(0, 500, 3'b100, NPIX, 3'b100, 1'b0);
        #3 rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_count", int'(count), 0);
        check("lit_rst_xmax", int'(xmax), 0);
        idle(2);
        #2 rst_n = 1'b1;
        frame(501, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b0);
        idle(3);
        check("lit_tail_count", int'(count), 0);
        check("lit_tail_found", int'(found), 0);
        frame(0, NPIX - 1, 3'b100, NPIX, 3'b100, 1'b0);
        idle(3);
        pin_box();

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
